// File: rtl/dscope_pkg.sv
// Shared definitions for the frame collector: FSM states, header field
// layout and width helpers. FRAME_HEADER_EN adds the HDR state.
package dscope_pkg;

    // Header word layout: frame counter in the upper bits, length sum below.
    localparam int unsigned HDR_LEN_LSB = 0;
    localparam int unsigned HDR_LEN_W   = 16;
    localparam int unsigned HDR_CNT_LSB = 16;

    // Output buffer depth and the occupancy width needed to count 0..2.
    localparam int unsigned BUF_DEPTH = 2;
    localparam int unsigned OCC_W     = $clog2(BUF_DEPTH + 1);

    // Index width for a count of n items; never narrower than one bit.
    function automatic int unsigned idx_w(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

`ifdef FRAME_HEADER_EN
    typedef enum logic [2:0] {
        ST_IDLE,
        ST_HDR,
        ST_SEL,
        ST_RUN,
        ST_DRAIN
    } fc_state_t;
`else
    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SEL,
        ST_RUN,
        ST_DRAIN
    } fc_state_t;
`endif

endpackage

// File: rtl/frame_collector_out_skid2.sv
// Two-entry output buffer with valid/ready drain and occupancy report.
// The writer must only push when there is room (occupancy after pop < 2).
module out_skid2
    import dscope_pkg::*;
#(
    parameter int unsigned DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              push,
    input  logic [DATA_W-1:0] push_data,
    output logic [DATA_W-1:0] out_data,
    output logic              out_vld,
    input  logic              out_rdy,
    output logic [OCC_W-1:0]  occ
);

    logic [DATA_W-1:0] head_q;
    logic [DATA_W-1:0] tail_q;
    logic [OCC_W-1:0]  occ_q;
    logic              pop;

    assign pop      = out_vld & out_rdy;
    assign out_vld  = (occ_q != '0);
    assign out_data = head_q;
    assign occ      = occ_q;

    // Head always holds the oldest word; tail only fills when head is busy.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            head_q <= '0;
            tail_q <= '0;
            occ_q  <= '0;
        end else begin
            case ({push, pop})
                2'b10: begin
                    if (occ_q == '0) head_q <= push_data;
                    else             tail_q <= push_data;
                    occ_q <= occ_q + OCC_W'(1);
                end
                2'b01: begin
                    head_q <= tail_q;
                    occ_q  <= occ_q - OCC_W'(1);
                end
                2'b11: begin
                    if (occ_q == OCC_W'(1)) begin
                        head_q <= push_data;
                    end else begin
                        head_q <= tail_q;
                        tail_q <= push_data;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: rtl/frame_collector.sv
// Frame collector: walks vchn/chn/addr over per-channel buffers and merges
// the words into one valid/ready stream through a 2-entry output buffer.
// Define FRAME_HEADER_EN to prefix each frame with a counter/length header.
module frame_collector
    import dscope_pkg::*;
#(
    parameter int unsigned CHN_COUNT  = 4,
    parameter int unsigned VCHN_COUNT = 4,
    parameter int unsigned ADDR_W     = 8,
    parameter int unsigned DATA_W     = 32
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          i_complite,
    output logic [$clog2(VCHN_COUNT)-1:0] o_rd_vchn,
    input  logic [CHN_COUNT*ADDR_W-1:0]   i_data_len,
    output logic [CHN_COUNT*ADDR_W-1:0]   o_rd_addr,
    input  logic [CHN_COUNT*DATA_W-1:0]   i_rd_data,
    output logic [DATA_W-1:0]             o_out_data,
    output logic                          o_out_vld,
    input  logic                          i_out_rdy,
    output logic                          o_busy,
    output logic                          o_frame_done,
    output logic                          o_drop
);

    localparam int unsigned VCHN_W = $clog2(VCHN_COUNT);
    localparam int unsigned CHN_W  = idx_w(CHN_COUNT);
    localparam logic [VCHN_W-1:0] LAST_VCHN = VCHN_W'(VCHN_COUNT - 1);
    localparam logic [CHN_W-1:0]  LAST_CHN  = CHN_W'(CHN_COUNT - 1);

    fc_state_t         state_q, state_d;
    logic [VCHN_W-1:0] vchn_q;
    logic [CHN_W-1:0]  chn_q;
    logic [ADDR_W-1:0] addr_q;
    logic [ADDR_W-1:0] len_q;
    logic [ADDR_W-1:0] cur_len;
    logic              inflight_q;
    logic [CHN_W-1:0]  inflight_chn_q;
    logic              done_q;
    logic              drop_q;

    logic              issue;
    logic              pair_end;
    logic              finish;
    logic              last_pair;
    logic              pop;
    logic              space;
    logic [OCC_W-1:0]  occ;
    logic [OCC_W:0]    occ_eff;
    logic              buf_push;
    logic [DATA_W-1:0] buf_data;
    logic [DATA_W-1:0] rd_word;

`ifdef FRAME_HEADER_EN
    localparam int unsigned CNT_W = DATA_W - HDR_CNT_LSB;
    logic [HDR_LEN_W-1:0] lane_sum;
    logic [HDR_LEN_W-1:0] len_sum_q;
    logic [CNT_W-1:0]     frame_cnt_q;
    logic [DATA_W-1:0]    hdr_word;
    logic                 hdr_push;
`endif

    assign o_rd_vchn    = vchn_q;
    assign o_busy       = (state_q != ST_IDLE);
    assign o_frame_done = done_q;
    assign o_drop       = drop_q;
    assign pop          = o_out_vld & i_out_rdy;
    assign last_pair    = (vchn_q == LAST_VCHN) && (chn_q == LAST_CHN);

    // Room check counts the word leaving this cycle, so a steady stream
    // keeps one read in flight and one word in the buffer every clock.
    assign occ_eff = {1'b0, occ} + {{OCC_W{1'b0}}, inflight_q} - {{OCC_W{1'b0}}, pop};
    assign space   = (occ_eff < (OCC_W + 1)'(BUF_DEPTH));

    // Lane muxes: length of the current channel, data of the in-flight read,
    // and the address bus with only the active lane driven.
    always_comb begin
        cur_len   = '0;
        rd_word   = '0;
        o_rd_addr = '0;
        for (int unsigned k = 0; k < CHN_COUNT; k++) begin
            if (chn_q == CHN_W'(k)) begin
                cur_len = i_data_len[k*ADDR_W +: ADDR_W];
                if (state_q == ST_SEL || state_q == ST_RUN)
                    o_rd_addr[k*ADDR_W +: ADDR_W] = addr_q;
            end
            if (inflight_chn_q == CHN_W'(k))
                rd_word = i_rd_data[k*DATA_W +: DATA_W];
        end
    end

`ifdef FRAME_HEADER_EN
    // Sum of all lane lengths for the vchn on o_rd_vchn, plus header word.
    always_comb begin
        lane_sum = '0;
        for (int unsigned k = 0; k < CHN_COUNT; k++)
            lane_sum = lane_sum + HDR_LEN_W'(i_data_len[k*ADDR_W +: ADDR_W]);
        hdr_word = '0;
        hdr_word[DATA_W-1:HDR_CNT_LSB]          = frame_cnt_q;
        hdr_word[HDR_LEN_LSB +: HDR_LEN_W]      = len_sum_q + lane_sum;
    end

    assign buf_push = inflight_q | hdr_push;
    assign buf_data = hdr_push ? hdr_word : rd_word;
`else
    assign buf_push = inflight_q;
    assign buf_data = rd_word;
`endif

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= ST_IDLE;
        else        state_q <= state_d;
    end

    // Next state and per-cycle controls. SEL issues address 0 itself so a
    // pair change costs no bubble; a length-1 pair never visits RUN.
    always_comb begin
        state_d  = state_q;
        issue    = 1'b0;
        pair_end = 1'b0;
        finish   = 1'b0;
`ifdef FRAME_HEADER_EN
        hdr_push = 1'b0;
`endif
        case (state_q)
            ST_IDLE: begin
                if (i_complite) begin
`ifdef FRAME_HEADER_EN
                    state_d = ST_HDR;
`else
                    state_d = ST_SEL;
`endif
                end
            end
`ifdef FRAME_HEADER_EN
            ST_HDR: begin
                if (vchn_q == LAST_VCHN) begin
                    hdr_push = 1'b1;
                    state_d  = ST_SEL;
                end
            end
`endif
            ST_SEL: begin
                if (cur_len == '0) begin
                    pair_end = 1'b1;
                    state_d  = last_pair ? ST_DRAIN : ST_SEL;
                end else if (space) begin
                    issue = 1'b1;
                    if (cur_len == ADDR_W'(1)) begin
                        pair_end = 1'b1;
                        state_d  = last_pair ? ST_DRAIN : ST_SEL;
                    end else begin
                        state_d = ST_RUN;
                    end
                end
            end
            ST_RUN: begin
                if (space) begin
                    issue = 1'b1;
                    if (addr_q == len_q - ADDR_W'(1)) begin
                        pair_end = 1'b1;
                        state_d  = last_pair ? ST_DRAIN : ST_SEL;
                    end
                end
            end
            ST_DRAIN: begin
                if (!inflight_q && (occ == '0 || (occ == OCC_W'(1) && pop))) begin
                    finish  = 1'b1;
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Read walk: address within the pair, then chn, then vchn.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vchn_q         <= '0;
            chn_q          <= '0;
            addr_q         <= '0;
            len_q          <= '0;
            inflight_q     <= 1'b0;
            inflight_chn_q <= '0;
            done_q         <= 1'b0;
            drop_q         <= 1'b0;
        end else begin
            inflight_q     <= issue;
            inflight_chn_q <= chn_q;
            done_q         <= finish;
            drop_q         <= i_complite & (state_q != ST_IDLE);
            if (state_q == ST_IDLE) begin
                vchn_q <= '0;
                chn_q  <= '0;
                addr_q <= '0;
`ifdef FRAME_HEADER_EN
            end else if (state_q == ST_HDR) begin
                vchn_q <= vchn_q + VCHN_W'(1);
`endif
            end else begin
                if (issue) begin
                    addr_q <= addr_q + ADDR_W'(1);
                    if (state_q == ST_SEL) len_q <= cur_len;
                end
                if (pair_end) begin
                    addr_q <= '0;
                    if (chn_q == LAST_CHN) begin
                        chn_q  <= '0;
                        vchn_q <= vchn_q + VCHN_W'(1);
                    end else begin
                        chn_q <= chn_q + CHN_W'(1);
                    end
                end
            end
        end
    end

`ifdef FRAME_HEADER_EN
    // Length sum accumulates across HDR; frame counter steps on completion.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            len_sum_q   <= '0;
            frame_cnt_q <= '0;
        end else begin
            if (state_q == ST_IDLE)     len_sum_q <= '0;
            else if (state_q == ST_HDR) len_sum_q <= len_sum_q + lane_sum;
            if (finish) frame_cnt_q <= frame_cnt_q + CNT_W'(1);
        end
    end
`endif

    out_skid2 #(
        .DATA_W (DATA_W)
    ) u_out_skid2 (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (buf_push),
        .push_data (buf_data),
        .out_data  (o_out_data),
        .out_vld   (o_out_vld),
        .out_rdy   (i_out_rdy),
        .occ       (occ)
    );

endmodule

// File: tb/tb_frame_collector.sv
// Self-checking bench for frame_collector with a queue-based reference
// model and a registered buffer memory. Honours FRAME_HEADER_EN.
module tb_frame_collector;

    localparam int unsigned CHN = 4;
    localparam int unsigned VCH = 4;
    localparam int unsigned AW  = 8;
    localparam int unsigned DW  = 32;
`ifdef FRAME_HEADER_EN
    localparam int LAT_MAX = VCH + 1;
`else
    localparam int LAT_MAX = 3;
`endif

    logic              clk = 1'b0;
    logic              rst_n = 1'b1;
    logic              i_complite = 1'b0;
    logic              i_out_rdy = 1'b0;
    logic [1:0]        o_rd_vchn;
    logic [CHN*AW-1:0] i_data_len;
    logic [CHN*AW-1:0] o_rd_addr;
    logic [CHN*DW-1:0] i_rd_data;
    logic [DW-1:0]     o_out_data;
    logic              o_out_vld, o_busy, o_frame_done, o_drop;

    frame_collector #(
        .CHN_COUNT  (CHN),
        .VCHN_COUNT (VCH),
        .ADDR_W     (AW),
        .DATA_W     (DW)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .i_complite   (i_complite),
        .o_rd_vchn    (o_rd_vchn),
        .i_data_len   (i_data_len),
        .o_rd_addr    (o_rd_addr),
        .i_rd_data    (i_rd_data),
        .o_out_data   (o_out_data),
        .o_out_vld    (o_out_vld),
        .i_out_rdy    (i_out_rdy),
        .o_busy       (o_busy),
        .o_frame_done (o_frame_done),
        .o_drop       (o_drop)
    );

    always #5 clk = ~clk;

    int len_tab[VCH][CHN];

    function automatic logic [DW-1:0] word_of(input int v, input int c, input int a);
        return {8'hC3, 8'(v), 8'(c), 8'(a)};
    endfunction

    // Length table seen through the selected vchn.
    always_comb begin
        i_data_len = '0;
        for (int k = 0; k < CHN; k++)
            i_data_len[k*AW +: AW] = AW'(len_tab[o_rd_vchn][k]);
    end

    // Buffer memory: data one cycle after the address.
    always @(posedge clk) begin
        for (int k = 0; k < CHN; k++)
            i_rd_data[k*DW +: DW] <= word_of(int'(o_rd_vchn), k, int'(o_rd_addr[k*AW +: AW]));
    end

    // Reference model state
    logic [DW-1:0] exp_q[$];
    bit            hdr_q[$];
    int  n_pass = 0, n_chk = 0;
    int  cyc = 0, last_acc = -100, frames_done = 0, words_acc = 0;
    bit  frame_active = 0, stall_prev = 0, exp_drop = 0;
    logic [DW-1:0] prev_data = '0;
    int  frame_cnt_m = 0, rdy_pct = 100, chain_left = 0;
    int  start_cyc = 0, first_acc_cyc = -1, first_data_cyc = 0, last_data_cyc = 0, data_idx = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
    endtask

    task automatic set_lens(input int mode);
        for (int v = 0; v < VCH; v++)
            for (int c = 0; c < CHN; c++)
                case (mode)
                    0: len_tab[v][c] = 3;
                    1: len_tab[v][c] = (c == 1) ? 0 : 2;
                    2: len_tab[v][c] = 255;
                    3: len_tab[v][c] = 1;
                    default: len_tab[v][c] = $urandom_range(6);
                endcase
    endtask

    // Expected word sequence of one frame straight from the read-order rule.
    task automatic start_frame_model();
        int sum = 0;
        logic [DW-1:0] h;
        for (int v = 0; v < VCH; v++)
            for (int c = 0; c < CHN; c++)
                for (int a = 0; a < len_tab[v][c]; a++) begin
                    exp_q.push_back(word_of(v, c, a));
                    hdr_q.push_back(1'b0);
                    sum++;
                end
        h = (DW'(frame_cnt_m) << 16) | DW'(sum % 65536);
`ifdef FRAME_HEADER_EN
        exp_q.push_front(h);
        hdr_q.push_front(1'b1);
`endif
        frame_active   = 1;
        data_idx       = 0;
        first_acc_cyc  = -1;
        start_cyc      = cyc;
    endtask

    // Data-word span with every output accept granted: contiguous words,
    // plus one cycle per zero-length pair between the first and last word.
    function automatic int exp_span();
        int words = 0, skips = 0, pend = 0;
        for (int v = 0; v < VCH; v++)
            for (int c = 0; c < CHN; c++)
                if (len_tab[v][c] == 0) begin
                    if (words > 0) pend++;
                end else begin
                    skips += pend;
                    pend = 0;
                    words += len_tab[v][c];
                end
        return words - 1 + skips;
    endfunction

    // One clock: observe at the falling edge, then drive the next inputs.
    task automatic cycle(input bit cpl_in);
        bit rdy, cpl, h;
        int nz;
        logic [DW-1:0] e;
        @(negedge clk);
        cpl = cpl_in;
        check("drop", o_drop, exp_drop);
        if (stall_prev) begin
            check("hold_vld", o_out_vld, 1);
            check("hold_data", o_out_data, prev_data);
        end
        nz = 0;
        for (int k = 0; k < CHN; k++) if (o_rd_addr[k*AW +: AW] != '0) nz++;
        check("addr_lanes", nz <= 1, 1);
        if (o_frame_done) begin
            check("done_busy", o_busy, 0);
            check("done_active", frame_active, 1);
            check("done_words_left", exp_q.size(), 0);
            check("done_delay", cyc - last_acc, 1);
            frame_active = 0;
            frames_done++;
            frame_cnt_m = (frame_cnt_m + 1) % 65536;
            if (chain_left > 0) begin
                cpl = 1;
                chain_left--;
            end
        end
        rdy = ($urandom_range(99) < rdy_pct);
        if (o_out_vld && rdy) begin
            check("word_expected", exp_q.size() > 0, 1);
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                h = hdr_q.pop_front();
                check("word", o_out_data, e);
                if (first_acc_cyc < 0) first_acc_cyc = cyc;
                if (!h) begin
                    if (data_idx == 0) first_data_cyc = cyc;
                    last_data_cyc = cyc;
                    data_idx++;
                end
            end
            last_acc = cyc;
            words_acc++;
        end
        exp_drop = cpl && o_busy;
        if (cpl && !o_busy) start_frame_model();
        stall_prev = o_out_vld && !rdy;
        prev_data  = o_out_data;
        i_out_rdy  = rdy;
        i_complite = cpl;
        cyc++;
    endtask

    task automatic wait_frames(input int target, input int budget);
        int n = 0;
        while (frames_done < target && n < budget) begin
            cycle(1'b0);
            n++;
        end
        check("frame_timeout", frames_done >= target, 1);
    endtask

    task automatic run_frame(input int pct, input int budget);
        int target;
        rdy_pct = pct;
        target  = frames_done + 1;
        cycle(1'b1);
        wait_frames(target, budget);
    endtask

    task automatic check_reset_outputs();
        check("rst_vld", o_out_vld, 0);
        check("rst_busy", o_busy, 0);
        check("rst_done", o_frame_done, 0);
        check("rst_drop", o_drop, 0);
        check("rst_vchn", o_rd_vchn, 0);
        check("rst_addr", o_rd_addr, 0);
        check("rst_data", o_out_data, 0);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        i_complite = 1'b0;
        i_out_rdy  = 1'b0;
        #1;
        check_reset_outputs();
        exp_q.delete();
        hdr_q.delete();
        frame_active = 0;
        frame_cnt_m  = 0;
        stall_prev   = 0;
        exp_drop     = 0;
        repeat (2) @(negedge clk);
        check_reset_outputs();
        rst_n = 1'b1;
    endtask

    initial begin
        int target, n;
        set_lens(0);
        do_reset();

        // All lengths 3, always ready: contiguous data and prompt first word
        set_lens(0);
        run_frame(100, 400);
        check("first_latency", (first_acc_cyc - start_cyc) <= LAT_MAX, 1);
        check("span_len3", last_data_cyc - first_data_cyc, exp_span());
        check("count_len3", data_idx, 48);

        // Channel 1 empty everywhere: one cycle per skipped pair
        set_lens(1);
        run_frame(100, 400);
        check("span_skip", last_data_cyc - first_data_cyc, exp_span());
        check("count_skip", data_idx, 24);

        // Long pairs with random back-pressure
        set_lens(2);
        run_frame(50, 30000);
        check("count_255", data_idx, 4080);

        // Start request while busy is dropped and the frame continues
        set_lens(0);
        rdy_pct = 70;
        target = frames_done + 1;
        cycle(1'b1);
        repeat (15) cycle(1'b0);
        check("busy_mid", o_busy, 1);
        cycle(1'b1);
        wait_frames(target, 1000);
        check("count_drop", data_idx, 48);

        // Reset part-way through a frame, then a clean frame
        set_lens(0);
        rdy_pct = 100;
        cycle(1'b1);
        target = words_acc + 10;
        n = 0;
        while (words_acc < target && n < 200) begin
            cycle(1'b0);
            n++;
        end
        check("reach_word10", words_acc >= target, 1);
        do_reset();
        repeat (3) cycle(1'b0);
        run_frame(100, 400);
        check("count_after_rst", data_idx, 48);

        // Three back-to-back frames started on the done pulse
        do_reset();
        set_lens(3);
        chain_left = 2;
        rdy_pct = 100;
        target = frames_done + 3;
        cycle(1'b1);
        wait_frames(target, 600);

        // Random lengths and back-pressure
        for (int f = 0; f < 3; f++) begin
            set_lens(4);
            run_frame(60, 3000);
        end
        repeat (3) cycle(1'b0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

    initial begin
        #5ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
